// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        S_FILL,
        S_RUN,
        S_HALT
    } fetch_state_e;

    localparam logic [63:0] NOP_INSTR = 64'd0;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value, input logic inc);
        if (inc && (value != 32'hFFFF_FFFF))
            return value + 32'd1;
        return value;
    endfunction

endpackage

// File: rtl/fetch_perf_counter.sv
// Saturating event counters for fetch stalls and redirect flushes.
module fetch_perf_counter
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        n_reset,
    input  logic        i_stall,
    input  logic        i_flush,
    output logic [31:0] o_stall_cnt,
    output logic [31:0] o_flush_cnt
);

    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            r_stall_cnt <= sat_inc32(r_stall_cnt, i_stall);
            r_flush_cnt <= sat_inc32(r_flush_cnt, i_flush);
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with one-cycle-latency memory and IF/ID register.
// Optional FETCH_PERF_CNT_EN adds stall/flush performance counter outputs.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int imem_addr_width = 10,
    parameter int instr_width     = 16
) (
    input  logic                       clk,
    input  logic                       n_reset,
    input  logic                       IF_stall_i,
    input  logic                       ID_stall_i,
    input  logic                       redirect_valid_i,
    input  logic [imem_addr_width-1:0] redirect_pc_i,
    input  logic                       halt_i,
    output logic [imem_addr_width-1:0] imem_addr_o,
    input  logic [instr_width-1:0]     imem_data_i,
    output logic [instr_width-1:0]     if_id_instr_o,
    output logic [imem_addr_width-1:0] if_id_pc_o,
    output logic                       if_id_valid_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                stall_cnt_o,
    output logic [31:0]                flush_cnt_o
`endif
);

    localparam logic [instr_width-1:0]     NOP    = NOP_INSTR[instr_width-1:0];
    localparam logic [imem_addr_width-1:0] PC_ONE = 1;

    fetch_state_e                 r_state,    w_state_nxt;
    logic [imem_addr_width-1:0]   r_pc,       w_pc_nxt;
    logic [imem_addr_width-1:0]   r_fetch_pc, w_fetch_pc_nxt;
    logic                         r_fetch_valid, w_fetch_valid_nxt;
    logic [instr_width-1:0]       r_if_id_instr, w_if_id_instr_nxt;
    logic [imem_addr_width-1:0]   r_if_id_pc,    w_if_id_pc_nxt;
    logic                         r_if_id_valid, w_if_id_valid_nxt;
    logic                         w_stall;

    assign w_stall = IF_stall_i | ID_stall_i;

    // While stalled, re-present the in-flight address so next cycle's data still matches fetch_pc.
    assign imem_addr_o = redirect_valid_i ? redirect_pc_i :
                         w_stall          ? r_fetch_pc    : r_pc;

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_fetch_pc_nxt    = r_fetch_pc;
        w_fetch_valid_nxt = r_fetch_valid;
        w_if_id_instr_nxt = r_if_id_instr;
        w_if_id_pc_nxt    = r_if_id_pc;
        w_if_id_valid_nxt = r_if_id_valid;

        if (redirect_valid_i) begin
            w_pc_nxt          = redirect_pc_i + PC_ONE;
            w_fetch_pc_nxt    = redirect_pc_i;
            w_fetch_valid_nxt = 1'b1;
            w_if_id_valid_nxt = 1'b0;
            w_if_id_instr_nxt = NOP;
            w_state_nxt       = S_RUN;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (!w_stall) begin
                        w_pc_nxt          = PC_ONE;
                        w_fetch_pc_nxt    = '0;
                        w_fetch_valid_nxt = 1'b1;
                        w_state_nxt       = S_RUN;
                    end
                end
                S_RUN: begin
                    if (!w_stall) begin
                        w_if_id_instr_nxt = r_fetch_valid ? imem_data_i : NOP;
                        w_if_id_pc_nxt    = r_fetch_pc;
                        w_if_id_valid_nxt = r_fetch_valid;
                        if (halt_i) begin
                            w_fetch_valid_nxt = 1'b0;
                            w_state_nxt       = S_HALT;
                        end else begin
                            w_pc_nxt          = r_pc + PC_ONE;
                            w_fetch_pc_nxt    = r_pc;
                            w_fetch_valid_nxt = 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    w_fetch_valid_nxt = 1'b0;
                    if (!ID_stall_i) begin
                        w_if_id_instr_nxt = NOP;
                        w_if_id_valid_nxt = 1'b0;
                    end
                end
                default: w_state_nxt = S_FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state       <= S_FILL;
            r_pc          <= '0;
            r_fetch_pc    <= '0;
            r_fetch_valid <= 1'b0;
            r_if_id_instr <= NOP;
            r_if_id_pc    <= '0;
            r_if_id_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_fetch_pc    <= w_fetch_pc_nxt;
            r_fetch_valid <= w_fetch_valid_nxt;
            r_if_id_instr <= w_if_id_instr_nxt;
            r_if_id_pc    <= w_if_id_pc_nxt;
            r_if_id_valid <= w_if_id_valid_nxt;
        end
    end

    assign if_id_instr_o = r_if_id_instr;
    assign if_id_pc_o    = r_if_id_pc;
    assign if_id_valid_o = r_if_id_valid;

`ifdef FETCH_PERF_CNT_EN
    fetch_perf_counter u_perf (
        .clk         (clk),
        .n_reset     (n_reset),
        .i_stall     (w_stall),
        .i_flush     (redirect_valid_i),
        .o_stall_cnt (stall_cnt_o),
        .o_flush_cnt (flush_cnt_o)
    );
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter imem_addr_width, default 10, word address width of PC and instruction memory.
REQ-002 SHALL have parameter instr_width, default 16, instruction word width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port n_reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port IF_stall_i  input  1  hold fetch (PC and in-flight fetch).
REQ-006 SHALL have port ID_stall_i  input  1  hold IF/ID register.
REQ-007 SHALL have port redirect_valid_i  input  1  taken branch/jump; flush and refetch.
REQ-008 SHALL have port redirect_pc_i  input  imem_addr_width  redirect target.
REQ-009 SHALL have port halt_i  input  1  stop fetching.
REQ-010 SHALL have port imem_addr_o  output  imem_addr_width  instruction memory address, sampled by memory at clk edge.
REQ-011 SHALL have port imem_data_i  input  instr_width  memory data, valid one cycle after address sampled.
REQ-012 SHALL have ports if_id_instr_o / if_id_pc_o / if_id_valid_o  output  instr_width / imem_addr_width / 1  IF/ID register contents.

Function
REQ-013 SHALL hold registers pc_r, fetch_pc_r, fetch_valid_r, IF/ID register, and state in {S_FILL, S_RUN, S_HALT}.
REQ-014 SHALL drive imem_addr_o = redirect_pc_i if redirect_valid_i, else fetch_pc_r if effective stall, else pc_r.
REQ-015 SHALL define effective stall = IF_stall_i | ID_stall_i (ID stall alone also freezes fetch; no instruction lost).
REQ-016 In S_RUN, no stall, no redirect: pc_r <= pc_r+1 (wraps modulo 2^imem_addr_width), fetch_pc_r <= pc_r, fetch_valid_r <= 1, IF/ID <= {imem_data_i, fetch_pc_r, fetch_valid_r}.
REQ-017 Under effective stall without redirect: pc_r, fetch_pc_r, fetch_valid_r, IF/ID all hold; re-read of fetch_pc_r keeps imem_data_i coherent next cycle.
REQ-018 Redirect has priority over stall and halt: pc_r <= redirect_pc_i+1, fetch_pc_r <= redirect_pc_i, fetch_valid_r <= 1, if_id_valid_o <= 0, state <= S_RUN; exactly one bubble.
REQ-019 S_FILL is the first cycle after reset: fetch_valid_r <= 1, pc_r <= 1, fetch_pc_r <= 0, IF/ID stays invalid; next state S_RUN.
REQ-020 halt_i in S_RUN (no redirect): state <= S_HALT, fetch_valid_r <= 0; the instruction already in flight still enters IF/ID if not stalled.
REQ-021 In S_HALT: pc_r holds, IF/ID loads invalid bubbles when not ID-stalled; exit only by redirect or reset.
REQ-022 When if_id_valid_o = 0, if_id_instr_o SHALL be NOP_INSTR.

Reset
REQ-023 On n_reset low, asynchronously: pc_r = 0, fetch_pc_r = 0, fetch_valid_r = 0, if_id_valid_o = 0, if_id_pc_o = 0, if_id_instr_o = NOP_INSTR, state = S_FILL.
REQ-024 Reset asserted mid-stall or mid-redirect SHALL override all inputs; first fetch after release is address 0.

Configuration
REQ-025 Macro FETCH_PERF_CNT_EN: when defined, SHALL add outputs stall_cnt_o and flush_cnt_o (32 bits each, reset 0, saturating at all-ones), counting effective-stall cycles and redirect cycles; when undefined, those ports and counters are absent and behaviour is otherwise identical.

Structure
REQ-026 Shared package SHALL hold fetch_state_e enum (S_FILL, S_RUN, S_HALT) and constant NOP_INSTR (all zeros).
REQ-027 Counters SHALL live in sub-module fetch_perf_counter, instantiated only under FETCH_PERF_CNT_EN.

Verification
REQ-028 Reset release, memory returns data = address: IF/ID valid from cycle 2 with pc 0,1,2,... consecutively.
REQ-029 IF_stall_i=ID_stall_i=1 for 3 cycles at if_id_pc_o=5: IF/ID holds pc 5 for 3 cycles, then 6,7 with no skip or duplicate.
REQ-030 redirect_valid_i=1, redirect_pc_i=0x40 while stalled: next cycle if_id_valid_o=0, following cycle if_id_pc_o=0x40 valid.
REQ-031 pc_r at 0x3FF (width 10): next fetched pc is 0x000.
REQ-032 halt_i at pc 8: pc 8 delivered, then bubbles indefinitely; redirect to 0x10 resumes at 0x10.
REQ-033 With FETCH_PERF_CNT_EN, 4 stall cycles and 2 redirects: stall_cnt_o=4, flush_cnt_o=2; n_reset mid-run clears both to 0.
